// File: rtl/victim_cache_pkg.sv
// Shared types and select encodings for the victim cache controller and datapath.
package victim_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL
  } victim_state_t;

  localparam logic DATA_IN_MEM      = 1'b0;
  localparam logic DATA_IN_CACHE    = 1'b1;
  localparam logic LINE_FROM_VICTIM = 1'b0;
  localparam logic LINE_FROM_PMEM   = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (inc && (count != '1)) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/victim_cache_control.sv
// Victim cache miss controller: resolves each main-cache miss as a victim swap or a
// pmem fill (with optional dirty writeback), driving datapath enables and the pmem port.
module victim_cache_control
  import victim_cache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 4,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_mask   = 2**s_offset
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mc_req,
  input  logic [31:0]       mem_address,
  input  logic              cache_valid,
  input  logic              victim_hit,
  input  logic              victim_valid_o,
  input  logic              victim_dirty_o,
  input  logic [s_tag-1:0]  victim_tag_o,
  input  logic              pmem_resp,
  output logic              mc_resp,
  output logic              mc_line_sel,
  output logic              victim_data_we,
  output logic              victim_tag_we,
  output logic              victim_valid_we,
  output logic              victim_dirty_we,
  output logic [s_mask-1:0] mask_val,
  output logic              data_in_sel,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  victim_state_t      state, next_state;
  logic [s_index-1:0] mem_index;
  logic               write_line;
  logic               hit_inc;
  logic               miss_inc;
  logic               unused_offset_bits;

  assign mem_index          = mem_address[s_offset +: s_index];
  assign unused_offset_bits = ^mem_address[s_offset-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state   = state;
    write_line   = 1'b0;
    mc_resp      = 1'b0;
    mc_line_sel  = LINE_FROM_VICTIM;
    data_in_sel  = DATA_IN_MEM;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;

    unique case (state)
      IDLE: begin
        if (mc_req) next_state = LOOKUP;
      end
      LOOKUP: begin
        if (victim_hit && victim_valid_o) begin
          // Both caches capture each other's line on the same edge.
          mc_resp     = 1'b1;
          write_line  = 1'b1;
          data_in_sel = DATA_IN_CACHE;
          hit_inc     = 1'b1;
          next_state  = IDLE;
        end else begin
          miss_inc   = 1'b1;
          next_state = (victim_valid_o && victim_dirty_o) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {victim_tag_o, mem_index, {s_offset{1'b0}}};
        if (pmem_resp) next_state = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
        if (pmem_resp) begin
          mc_resp     = 1'b1;
          mc_line_sel = LINE_FROM_PMEM;
          write_line  = 1'b1;
          data_in_sel = DATA_IN_CACHE;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign victim_data_we  = write_line;
  assign victim_tag_we   = write_line;
  assign victim_valid_we = write_line;
  assign victim_dirty_we = write_line;
  assign mask_val        = {s_mask{write_line}};

  sat_counter #(.WIDTH(32)) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(32)) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: doc/victim_cache_control.md
# victim_cache_control

Control FSM for the victim cache: drives the victim datapath's write enables, `data_in_sel` and `mask_val`, and arbitrates the physical-memory port on every main-cache miss. It sits between the main cache's miss interface and pmem and is the direct upstream controller of `victim_cache_datapath`. It resolves each miss in one of two ways:
- **Swap:** victim hit, where the victim line and the main cache's evicted line swap places.
- **Fill:** victim miss, an optional dirty writeback followed by a pmem read, with the evicted main-cache line installed in the victim.

## Interface
Parameters:
- `s_offset`, 5: byte-offset bits.
- `s_index`, 4: index bits, shared by the main cache and the victim.
- `s_tag`, `32-s_offset-s_index`: tag bits.
- `s_mask`, `2**s_offset`: bytes per line and width of `mask_val`.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `mc_req`  in  1: main-cache miss request. Held until `mc_resp`.
- `mem_address`  in  32: miss address. Stable while `mc_req`=1.
- `cache_valid`  in  1: the main cache's evicted line is valid. Stable while `mc_req`=1.
- `victim_hit`, `victim_valid_o`, `victim_dirty_o`  in  1 each: from the datapath.
- `victim_tag_o`  in  `s_tag`: from the datapath.
- `pmem_resp`  in  1: pmem completion, one-cycle pulse.
- `mc_resp`  out  1: miss resolved. The main cache latches its line this edge.
- `mc_line_sel`  out  1: selects the line source for the main cache. 0 = `victim_data_o`, 1 = `pmem_rdata`.
- `victim_data_we`, `victim_tag_we`, `victim_valid_we`, `victim_dirty_we`  out  1 each: datapath write enables.
- `mask_val`  out  `s_mask`: all ones whenever `victim_data_we`=1, otherwise 0.
- `data_in_sel`  out  1: datapath input select. 0 = mem path, 1 = main-cache path.
- `pmem_read`, `pmem_write`  out  1 each: pmem requests.
- `pmem_address`  out  32: pmem address.
- `hit_count`, `miss_count`  out  32 each: saturating event counters.

## Operation
- **States:** IDLE, LOOKUP, WRITEBACK, FILL.
- **IDLE:**
  - `mc_req`=1 → LOOKUP.
  - `data_in_sel`=0, so the datapath reads SRAM at `mem_index`.
- **LOOKUP:** SRAM outputs are valid in this state.
  - **Swap, `victim_hit & victim_valid_o`:**
    - Assert `mc_resp`=1 with `mc_line_sel`=0.
    - Assert `data_in_sel`=1 and all four write enables, so the evicted line is written with its valid/dirty bits (valid = `cache_valid`).
    - Increment `hit_count` and return to IDLE.
    - Both caches latch the pre-edge values at the same edge.
  - **Else `victim_valid_o & victim_dirty_o`:** → WRITEBACK.
  - **Else:** → FILL.
  - Every exit except the swap increments `miss_count`.
- **WRITEBACK:**
  - `pmem_write`=1, `pmem_address` = {`victim_tag_o`, `mem_index`, `s_offset`'b0}.
  - No victim writes occur, so the SRAM output holds.
  - On `pmem_resp` → FILL.
- **FILL:**
  - `pmem_read`=1, `pmem_address` = {`mem_address[31:s_offset]`, `s_offset`'b0}.
  - On the `pmem_resp` cycle, asserted combinationally (Mealy):
    - `mc_resp`=1 with `mc_line_sel`=1.
    - `data_in_sel`=1 with all four write enables, installing the evicted main-cache line at the same index.
  - → IDLE.
- **Idle defaults:** all write enables, `mask_val`, `pmem_read`, `pmem_write` and `mc_resp` are 0. `pmem_address` is 0 outside WRITEBACK and FILL.
- **Counters:** saturate at 0xFFFF_FFFF and do not wrap.

## Timing
- **Reset:** asynchronous reset forces IDLE and drives every output and both counters to 0 immediately. An in-flight pmem request is dropped.
- **Swap latency:** `mc_req` rising edge to `mc_resp` is 2 cycles (IDLE, then LOOKUP).
- **Fill latency:** 2 cycles plus the pmem latency, plus one extra pmem transaction when a writeback is needed.
- **pmem handshake:**
  - `pmem_read`/`pmem_write` stay high until the cycle `pmem_resp` is seen, and drop on the next cycle.
  - `pmem_read` and `pmem_write` are never both high.
- **`mc_resp`:** exactly one cycle per request. After `mc_resp`, the next `mc_req` is accepted no earlier than the following cycle in IDLE.
- **Spurious response:** `pmem_resp` in IDLE or LOOKUP is ignored.
- **Request dropped mid-operation:** protocol violation. The FSM finishes its current transaction regardless.

## Structure
- **Shared package `victim_cache_pkg`:**
  - State enum `victim_state_t` (IDLE, LOOKUP, WRITEBACK, FILL).
  - Constants `DATA_IN_MEM`=0 and `DATA_IN_CACHE`=1.
  - Constants `LINE_FROM_VICTIM`=0 and `LINE_FROM_PMEM`=1.
- **One sub-module, `sat_counter`** (32-bit saturating increment), instantiated twice.
- The top level also instantiates `victim_cache_datapath` and this block.

## Test plan
- **Swap hit:** preload index 3 with valid tag 0x1234. `mc_req` at `mem_address`={0x1234, 3, 0}, `cache_valid`=1 → `mc_resp` in cycle 2, `mc_line_sel`=0, all write enables with `data_in_sel`=1, `hit_count`=1, no pmem activity.
- **Clean miss:** victim index 5 invalid. `mc_req` at 0x0000_00A0 → `pmem_read` with `pmem_address`=0x0000_00A0. `pmem_resp` after 4 cycles → same-cycle `mc_resp`, `mc_line_sel`=1, `miss_count`=1.
- **Dirty miss:** victim index 2 valid, dirty, tag 0x7. `mc_req` at a different tag → `pmem_write` to {0x7, 2, 0} until `pmem_resp`, then `pmem_read` of the miss line, then `mc_resp`. `pmem_read` and `pmem_write` never overlap.
- **Mid-operation reset:** assert `rst` during WRITEBACK → all outputs 0 asynchronously. After release, state is IDLE and both counters are 0.
- **Spurious response and counters:** `pmem_resp` pulses in IDLE → no state change. Force `hit_count`=0xFFFF_FFFF and run one hit → count stays 0xFFFF_FFFF.
